// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative signed/unsigned multiply/divide engine producing HI/LO
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             op_div_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             divzero_o
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state, nextState;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   accHi, accLo, opB, aRaw;
    logic               negQ, negR;
    logic [WIDTH-1:0]   hiReg, loReg;
    logic               divzeroReg;

    logic               accept, lastIter, divByZero;
    logic [WIDTH-1:0]   aMag, bMag, mulAddend;
    logic [WIDTH:0]     mulSum, divShift, divTrial;
    logic [WIDTH-1:0]   mulHi, mulLo, divHi, divLo;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quoFix, remFix;

    assign accept    = (state == IDLE) && start_i && !cancel_i;
    assign lastIter  = (cnt == CNT_W'(WIDTH - 1));
    assign divByZero = (state == DIV) && (opB == '0);

    assign hi_o      = hiReg;
    assign lo_o      = loReg;
    assign divzero_o = divzeroReg;

    // Operand magnitudes and one iteration of each algorithm, plus the final sign fix
    always_comb begin
        aMag      = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
        bMag      = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

        // shift-add: add multiplicand into the upper half, shift the pair right
        mulAddend = accLo[0] ? opB : '0;
        mulSum    = {1'b0, accHi} + {1'b0, mulAddend};
        mulHi     = mulSum[WIDTH:1];
        mulLo     = {mulSum[0], accLo[WIDTH-1:1]};

        // restoring divide: accHi is the partial remainder, accLo shifts dividend out / quotient in
        divShift  = {accHi, accLo[WIDTH-1]};
        divTrial  = divShift - {1'b0, opB};
        divHi     = divTrial[WIDTH] ? divShift[WIDTH-1:0] : divTrial[WIDTH-1:0];
        divLo     = {accLo[WIDTH-2:0], ~divTrial[WIDTH]};

        prodFix   = negQ ? -{mulHi, mulLo} : {mulHi, mulLo};
        quoFix    = negQ ? -divLo : divLo;
        remFix    = negR ? -divHi : divHi;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    // Next-state logic; cancel always returns to IDLE without a done pulse
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (accept) nextState = op_div_i ? DIV : MUL;
            MUL:  if (cancel_i) nextState = IDLE;
                  else if (lastIter) nextState = DONE;
            DIV:  if (cancel_i) nextState = IDLE;
                  else if (divByZero || lastIter) nextState = DONE;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Outputs decoded from the state register only, so they carry no input timing
    always_comb begin
        busy_o = (state == MUL) || (state == DIV);
        done_o = (state == DONE);
    end

    // Working registers: load on accept, iterate while busy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            accHi <= '0;
            accLo <= '0;
            opB   <= '0;
            aRaw  <= '0;
            negQ  <= 1'b0;
            negR  <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            accHi <= '0;
            accLo <= aMag;
            opB   <= bMag;
            aRaw  <= a_i;
            negQ  <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            negR  <= signed_i && a_i[WIDTH-1];
        end else if ((state == MUL || state == DIV) && !cancel_i) begin
            cnt   <= cnt + CNT_W'(1);
            accHi <= (state == DIV) ? divHi : mulHi;
            accLo <= (state == DIV) ? divLo : mulLo;
        end
    end

    // Result registers: updated only by a completed operation, held across cancel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hiReg      <= '0;
            loReg      <= '0;
            divzeroReg <= 1'b0;
        end else if (accept) begin
            divzeroReg <= 1'b0;
        end else if (!cancel_i) begin
            if (divByZero) begin
                hiReg      <= aRaw;
                loReg      <= '1;
                divzeroReg <= 1'b1;
            end else if (state == MUL && lastIter) begin
                {hiReg, loReg} <= prodFix;
            end else if (state == DIV && lastIter) begin
                hiReg <= remFix;
                loReg <= quoFix;
            end
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the EX stage. It computes the HI/LO pair for MULT/MULTU/DIV/DIVU over multiple cycles.
- It drives the hazard unit's divide-busy stall input and supplies the values that the hilo register stores.
- It generalises the current single-cycle ALU hi/lo path with:
  - a configurable operand width,
  - both multiply and divide in one sequential engine,
  - signed/unsigned modes,
  - divide-by-zero reporting,
  - pipeline-flush cancellation.

Parameters:
- WIDTH, 32, operand width in bits (>= 4). HI and LO are WIDTH bits each. Iteration count is WIDTH.
- CNT_W, $clog2(WIDTH)+1, iteration counter width. Derived; do not override.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- start_i  input  1  request an operation; sampled only in IDLE
- op_div_i  input  1  0 = multiply, 1 = divide; sampled with start_i
- signed_i  input  1  1 = two's-complement operands; sampled with start_i
- a_i  input  WIDTH  multiplicand / dividend
- b_i  input  WIDTH  multiplier / divisor
- cancel_i  input  1  flush; abort any operation in progress
- busy_o  output  1  high in MUL or DIV state; to hazard stall logic
- done_o  output  1  one-cycle pulse; hi_o/lo_o valid
- hi_o  output  WIDTH  mul: upper product half; div: remainder
- lo_o  output  WIDTH  mul: lower product half; div: quotient
- divzero_o  output  1  high with done_o when the divisor was zero; held until the next accepted start

Behaviour:
- Reset (rst=0, async):
  - state = IDLE, counter = 0.
  - busy_o = 0, done_o = 0, divzero_o = 0.
  - hi_o = 0, lo_o = 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start_i=1, cancel_i=0 at edge T0:
  - Latch the operand magnitudes. When signed_i=1, take the absolute value of each negative operand.
  - Latch the result-sign flags:
    - quotient/product sign = sign(a) XOR sign(b);
    - remainder sign = sign(a).
  - Clear divzero_o.
  - Go to MUL or DIV according to op_div_i.
- IDLE, start_i=1 and cancel_i=1 in the same cycle: cancel wins. Remain in IDLE.
- MUL: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
  - After WIDTH iterations (edge T0+WIDTH), apply the sign fix and load hi_o/lo_o. Go to DONE.
- DIV: restoring division, one quotient bit per cycle.
  - After WIDTH iterations (edge T0+WIDTH), apply the sign fix and load hi_o/lo_o. Go to DONE.
- Sign fix uses the two's-complement negate of the raw magnitude result:
  - product: negate the full 2*WIDTH value;
  - quotient: negate per the quotient sign flag;
  - remainder: negate per the remainder sign flag.
- Divide by zero (b magnitude = 0):
  - DIV finishes at edge T0+1.
  - hi_o = a_i as sampled, lo_o = all ones, divzero_o = 1.
  - Go to DONE.
- Signed overflow: the most negative value divided by -1 gives lo_o = 100..0 and hi_o = 0. No flag is raised.
- DONE:
  - done_o = 1 for exactly one cycle, then return to IDLE.
  - hi_o/lo_o hold until the next completed operation.
  - A start_i arriving in DONE is ignored.
- start_i while busy_o=1: ignored. The operation in progress is unaffected.
- cancel_i in MUL, DIV or DONE:
  - next edge goes to IDLE;
  - done_o is not pulsed (DONE: done_o deasserts);
  - hi_o/lo_o/divzero_o keep their previous values.
- Latency: done_o is high in cycle T0+WIDTH+1 (after edge T0+WIDTH). For divide by zero, done_o is high in cycle T0+2.
- busy_o is registered. The hazard unit ORs in the start request itself to stall in the issue cycle.
- Reset asserted mid-operation: immediate return to the reset values. No done_o is pulsed.

Test Plan:
- Unsigned multiply, WIDTH=32: start, op_div=0, signed=0, a=0xFFFFFFFF, b=2.
  - Expect busy_o for 32 cycles, then done_o for 1 cycle, with hi_o=0x00000001, lo_o=0xFFFFFFFE.
- Signed multiply: a=-3, b=5.
  - Expect hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1.
- Signed divide: a=-7, b=2.
  - Expect lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1).
- Unsigned divide: a=100, b=7.
  - Expect lo_o=14, hi_o=2, divzero_o=0.
- Divide by zero: a=0x1234, b=0, op_div=1.
  - Expect done_o in the 2nd cycle after start, hi_o=0x1234, lo_o=0xFFFFFFFF, divzero_o=1.
- Interference during an operation:
  - start a divide, assert start_i again at cycle 5 with other operands: ignored, original result is produced;
  - assert cancel_i at cycle 10: busy_o drops next cycle, no done_o, hi_o/lo_o unchanged;
  - pull rst low mid-multiply: all outputs go to 0 immediately.
